// File: rtl/mips_dmem_responder.sv
// mips_dmem_responder: single-cycle MIPS data-port responder decoding RAM, MMIO counters/status and a TX byte FIFO.
module mips_dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] aluout,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  logic [31:0] ram [DEPTH_WORDS];
  logic [7:0] fifo [FIFO_DEPTH];
  logic [31:0] cycle, stores, status;
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic [AW-1:0] idx;
  logic [1:0] off;
  logic ovf, ram_sel, mmio_sel, mis, wr_ok, ram_we, bad_wr, push, pop, full, accept, drop, clr;
  always_comb begin
    idx = aluout[AW+1:2];
    off = aluout[3:2];
    ram_sel = aluout < 32'(DEPTH_WORDS * 4);
    mmio_sel = aluout[31:16] == 16'hFFFF && aluout[15:4] == 12'h000;
    mis = memwrite && aluout[1:0] != 2'b00;
    wr_ok = memwrite && !mis && !reset;
    ram_we = wr_ok && ram_sel;
    bad_wr = memwrite && (mis || !(ram_sel || mmio_sel));
    tx_valid = cnt != '0;
    tx_data = fifo[rp];
    full = cnt == CW'(FIFO_DEPTH);
    pop = tx_valid && tx_ready;
    push = wr_ok && mmio_sel && off == 2'd2;
    accept = push && (!full || pop);
    drop = push && !accept;
    clr = wr_ok && mmio_sel && off == 2'd3 && writedata[2];
    status = {25'h0, 4'(cnt), ovf, full, cnt == '0};
    readdata = ram_sel ? ram[idx]
             : mmio_sel ? (off == 2'd0 ? cycle : off == 2'd1 ? stores : off == 2'd2 ? 32'h0 : status)
             : 32'h0;
  end
  // Storage arrays are never reset; only their write enables respect reset.
  always_ff @(posedge clk) begin
    if (ram_we) ram[idx] <= writedata;
    if (accept) fifo[wp] <= writedata[7:0];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle <= '0;
      stores <= '0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      err <= 1'b0;
    end else begin
      cycle <= cycle + 32'd1;
      stores <= stores + 32'(ram_we);
      err <= bad_wr;
      if (accept) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + CW'(accept) - CW'(pop);
      ovf <= drop | (ovf & ~clr);
    end
  end
endmodule

// File: tb/tb_mips_dmem_responder.sv
// tb_mips_dmem_responder: directed test plan plus random traffic checked against a queue/array reference model.
module tb_mips_dmem_responder;
  localparam int DW = 64;
  localparam int FD = 4;
  logic clk, rst, mw, rdy, tx_valid, err;
  logic [31:0] a, wd, readdata;
  logic [7:0] tx_data;
  int total = 0;
  int bad = 0;
  logic [31:0] mc, ms;
  logic [31:0] mram [int];
  logic [7:0] q [$];
  bit movf, merr, mknown;

  mips_dmem_responder #(.DEPTH_WORDS(DW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(rst), .memwrite(mw), .aluout(a), .writedata(wd),
    .readdata(readdata), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(rdy), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit is_ram(input logic [31:0] ad);
    return ad < 32'(DW * 4);
  endfunction

  function automatic bit is_mmio(input logic [31:0] ad);
    return ad[31:16] == 16'hFFFF && ad[15:4] == 12'h0;
  endfunction

  function automatic logic [31:0] mmio_exp(input logic [31:0] ad);
    case (ad[3:2])
      2'd0: return mc;
      2'd1: return ms;
      2'd2: return 32'h0;
      default: return {25'd0, 4'(q.size()), movf, q.size() == FD, q.size() == 0};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] ad, input logic [31:0] d, input logic y);
    rst = r; mw = w; a = ad; wd = d; rdy = y;
    #1;
    if (is_ram(a)) begin
      if (mram.exists(int'(a[31:2]))) chk("model_ram", readdata, mram[int'(a[31:2])]);
    end else if (!is_mmio(a)) chk("model_unmapped", readdata, 32'h0);
    else if (mknown) chk("model_mmio", readdata, mmio_exp(a));
    if (mknown) begin
      chk("model_txv", {31'b0, tx_valid}, {31'b0, q.size() != 0});
      if (q.size() != 0) chk("model_txd", {24'b0, tx_data}, {24'b0, q[0]});
      chk("model_err", {31'b0, err}, {31'b0, merr});
    end
  endtask

  task automatic tick();
    bit mis, pop;
    @(posedge clk);
    if (rst) begin
      mc = 0; ms = 0; q.delete(); movf = 0; merr = 0; mknown = 1;
    end else begin
      mis = mw && a[1:0] != 2'b00;
      merr = mw && (mis || !(is_ram(a) || is_mmio(a)));
      pop = q.size() != 0 && rdy;
      if (mw && !mis && is_ram(a)) begin
        mram[int'(a[31:2])] = wd;
        ms++;
      end
      if (pop) void'(q.pop_front());
      if (mw && !mis && is_mmio(a) && a[3:2] == 2'd3 && wd[2]) movf = 0;
      if (mw && !mis && is_mmio(a) && a[3:2] == 2'd2) begin
        if (q.size() < FD) q.push_back(wd[7:0]);
        else movf = 1;
      end
      mc++;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] ra;
    mknown = 0;
    drive(1, 1, 32'h0, 32'h0, 0); tick();
    drive(1, 0, 32'hFFFF0000, 0, 0); chk("rst_cycle", readdata, 32'h0); tick();
    drive(1, 0, 32'hFFFF0004, 0, 0); chk("rst_stores", readdata, 32'h0);
    chk("rst_txv", {31'b0, tx_valid}, 32'h0); chk("rst_err", {31'b0, err}, 32'h0); tick();
    for (int k = 0; k < 7; k++) begin
      drive(0, 0, 32'hFFFF0000, 0, 0);
      chk("cycle_count", readdata, 32'(k));
      tick();
    end
    drive(0, 1, 32'h4, 32'hDEADBEEF, 0); tick();
    drive(0, 1, 32'h8, 32'hCAFEBABE, 0); tick();
    drive(0, 0, 32'h4, 0, 0); chk("ram_rd4", readdata, 32'hDEADBEEF); tick();
    drive(0, 0, 32'h8, 0, 0); chk("ram_rd8", readdata, 32'hCAFEBABE); tick();
    drive(0, 1, 32'h4, 32'h12345678, 0); chk("ram_old", readdata, 32'hDEADBEEF); tick();
    drive(0, 0, 32'h4, 0, 0); chk("ram_new", readdata, 32'h12345678); tick();
    drive(0, 0, 32'hFFFF0004, 0, 0); chk("stores3", readdata, 32'd3); tick();
    drive(0, 1, 32'h1000, 32'h55, 0); chk("unmap_rd", readdata, 32'h0); tick();
    drive(0, 0, 32'hFFFF0004, 0, 0); chk("unmap_err", {31'b0, err}, 32'h1);
    chk("unmap_stores", readdata, 32'd3); tick();
    drive(0, 1, 32'h6, 32'hFFFFFFFF, 0); chk("err_once", {31'b0, err}, 32'h0); tick();
    drive(0, 0, 32'h4, 0, 0); chk("mis_err", {31'b0, err}, 32'h1);
    chk("mis_ram", readdata, 32'h12345678); tick();
    for (int i = 0; i < 5; i++) begin drive(0, 1, 32'hFFFF0008, 32'h41 + 32'(i), 0); tick(); end
    drive(0, 0, 32'hFFFF000C, 0, 0); chk("stat_full", readdata, 32'h26);
    chk("head41", {24'b0, tx_data}, 32'h41); tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 32'hFFFF000C, 0, 1); chk("drain", {24'b0, tx_data}, 32'h41 + 32'(i)); tick();
    end
    drive(0, 0, 32'hFFFF000C, 0, 0); chk("stat_ovf", readdata, 32'h5); tick();
    drive(0, 1, 32'hFFFF000C, 32'h4, 0); tick();
    drive(0, 0, 32'hFFFF000C, 0, 0); chk("stat_clr", readdata, 32'h1); tick();
    for (int i = 0; i < 4; i++) begin drive(0, 1, 32'hFFFF0008, 32'h60 + 32'(i), 0); tick(); end
    drive(0, 1, 32'hFFFF0008, 32'h50, 1); tick();
    drive(0, 0, 32'hFFFF000C, 0, 0); chk("pushpop_stat", readdata, 32'h22); tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 32'hFFFF000C, 0, 1);
      chk("pushpop_order", {24'b0, tx_data}, i == 3 ? 32'h50 : 32'h61 + 32'(i));
      tick();
    end
    for (int i = 0; i < 3; i++) begin drive(0, 1, 32'hFFFF0008, 32'h70 + 32'(i), 0); tick(); end
    drive(1, 0, 32'hFFFF000C, 0, 1); tick();
    drive(0, 0, 32'hFFFF000C, 0, 0); chk("rst_drain_txv", {31'b0, tx_valid}, 32'h0);
    chk("rst_drain_stat", readdata, 32'h1); tick();
    drive(0, 0, 32'h8, 0, 0); chk("ram_keep", readdata, 32'hCAFEBABE); tick();
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 5))
        0, 1: begin
          ra = {24'h0, 8'($urandom)};
          if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
        end
        2, 3: ra = {16'hFFFF, 12'h000, 2'($urandom), ($urandom_range(0, 7) == 0) ? 2'b01 : 2'b00};
        4: ra = {16'hFFFF, 12'h010, 4'h0};
        default: ra = 32'h1000 + {20'h0, 10'($urandom), 2'b00};
      endcase
      drive($urandom_range(0, 59) == 0, 1'($urandom), ra, $urandom, 1'($urandom));
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
